// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: write-back arbiter bus bundle.
//   master: the producer side (ALU stream, long-latency source, register-file observer)
//   slave : the arbiter itself
//   alu_*  : ALU result stream; alu_stall_o holds it off
//   lat_*  : long-latency result stream, valid/ready
//   reg_*  : registered register-file write port
//   pend_mask_o : registers with a write still queued or on the write port
interface wb_arbiter_if;
    logic        alu_wen_i;
    logic [4:0]  alu_waddr_i;
    logic [63:0] alu_wdata_i;
    logic        alu_stall_o;
    logic        lat_valid_i;
    logic        lat_ready_o;
    logic [4:0]  lat_waddr_i;
    logic [63:0] lat_wdata_i;
    logic        reg_wen_o;
    logic [4:0]  reg_waddr_o;
    logic [63:0] reg_wdata_o;
    logic [31:0] pend_mask_o;

    modport master (
        output alu_wen_i, alu_waddr_i, alu_wdata_i, lat_valid_i, lat_waddr_i, lat_wdata_i,
        input  alu_stall_o, lat_ready_o, reg_wen_o, reg_waddr_o, reg_wdata_o, pend_mask_o
    );
    modport slave (
        input  alu_wen_i, alu_waddr_i, alu_wdata_i, lat_valid_i, lat_waddr_i, lat_wdata_i,
        output alu_stall_o, lat_ready_o, reg_wen_o, reg_waddr_o, reg_wdata_o, pend_mask_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges the ALU result stream and a long-latency result stream
// onto one registered 64-bit register-file write port.
//   clk, rst : clock, synchronous active-high reset
//   bus      : wb_arbiter_if.slave (alu_*, lat_*, reg_*, pend_mask_o)
//   stat_conflict_o : only with WB_ARB_STATS_EN defined; saturating count of
//                     cycles where the ALU won while the FIFO held a result
// Priority: ALU, then FIFO head, then same-cycle lat bypass when the FIFO is empty.
module wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave bus
`ifdef WB_ARB_STATS_EN
    ,
    output logic [31:0] stat_conflict_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [4:0]    q_addr [DEPTH];
    logic [63:0]   q_data [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, wr_n, rd_n, cnt_n;
    logic [CW-1:0] starve;
    logic          empty, full_n, alu_go, lat_nz, pop, bypass, push, wen_n;
    logic [4:0]    waddr_n;
    logic [63:0]   wdata_n;
    logic [31:0]   pend_n;

    assign bus.alu_stall_o = starve == CW'(STARVE_LIMIT);

    // Everything registered is computed from next state, so pend_mask_o and
    // lat_ready_o move in the same cycle as the FIFO and the write port.
    always_comb begin
        empty   = wr_ptr == rd_ptr;
        alu_go  = bus.alu_wen_i && !bus.alu_stall_o && |bus.alu_waddr_i;
        lat_nz  = bus.lat_valid_i && bus.lat_ready_o && |bus.lat_waddr_i;
        pop     = !alu_go && !empty;
        bypass  = !alu_go && empty && lat_nz;
        push    = lat_nz && !bypass;
        wr_n    = wr_ptr + PW'(push);
        rd_n    = rd_ptr + PW'(pop);
        cnt_n   = wr_n - rd_n;
        full_n  = (wr_n[AW] != rd_n[AW]) && (wr_n[AW-1:0] == rd_n[AW-1:0]);
        wen_n   = alu_go || pop || bypass;
        waddr_n = alu_go ? bus.alu_waddr_i : pop ? q_addr[rd_ptr[AW-1:0]] : bus.lat_waddr_i;
        wdata_n = alu_go ? bus.alu_wdata_i : pop ? q_data[rd_ptr[AW-1:0]] : bus.lat_wdata_i;
        pend_n  = wen_n ? 32'd1 << waddr_n : 32'd0;
        for (int i = 0; i < DEPTH; i++)
            if (PW'(AW'(AW'(i) - rd_n[AW-1:0])) < cnt_n)
                pend_n[(push && wr_ptr[AW-1:0] == AW'(i)) ? bus.lat_waddr_i : q_addr[i]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            starve          <= '0;
            bus.lat_ready_o <= 1'b0;
            bus.reg_wen_o   <= 1'b0;
            bus.reg_waddr_o <= '0;
            bus.reg_wdata_o <= '0;
            bus.pend_mask_o <= '0;
        end else begin
            if (push) begin
                q_addr[wr_ptr[AW-1:0]] <= bus.lat_waddr_i;
                q_data[wr_ptr[AW-1:0]] <= bus.lat_wdata_i;
            end
            wr_ptr          <= wr_n;
            rd_ptr          <= rd_n;
            starve          <= (alu_go && !empty) ? starve + 1'b1 : '0;
            bus.lat_ready_o <= !full_n;
            bus.reg_wen_o   <= wen_n;
            bus.reg_waddr_o <= waddr_n;
            bus.reg_wdata_o <= wdata_n;
            bus.pend_mask_o <= pend_n;
        end
    end

`ifdef WB_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            stat_conflict_o <= '0;
        else if (alu_go && !empty && !(&stat_conflict_o))
            stat_conflict_o <= stat_conflict_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of wb_arbiter against a queue-based model.
module tb_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
    typedef struct packed {logic [4:0] a; logic [63:0] d;} wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if bus();
`ifdef WB_ARB_STATS_EN
    logic [31:0] stat;
`endif

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef WB_ARB_STATS_EN
        ,
        .stat_conflict_o(stat)
`endif
    );

    int          total = 0;
    int          bad = 0;
    wr_t         q[$];
    logic        m_wen, m_ready;
    logic [4:0]  m_addr;
    logic [63:0] m_data;
    logic [31:0] m_pend;
    int          m_starve;
    longint      m_stat;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of the arbiter's rules, applied to the inputs currently driven.
    task automatic model();
        bit  alu_go, acc, taken;
        wr_t w;
        if (rst) begin
            q.delete();
            {m_wen, m_ready, m_addr, m_data, m_pend} = '0;
            m_starve = 0;
            m_stat = 0;
            return;
        end
        alu_go = bus.alu_wen_i && m_starve != LIMIT && bus.alu_waddr_i != 0;
        acc    = bus.lat_valid_i && m_ready && bus.lat_waddr_i != 0;
        taken  = 0;
        if (alu_go && q.size() > 0) begin
            m_starve++;
            if (m_stat < 64'hFFFF_FFFF) m_stat++;
        end else m_starve = 0;
        m_wen = 1;
        if (alu_go) begin
            m_addr = bus.alu_waddr_i;
            m_data = bus.alu_wdata_i;
        end else if (q.size() > 0) begin
            w = q.pop_front();
            m_addr = w.a;
            m_data = w.d;
        end else if (acc) begin
            m_addr = bus.lat_waddr_i;
            m_data = bus.lat_wdata_i;
            taken = 1;
        end else m_wen = 0;
        if (acc && !taken) q.push_back({bus.lat_waddr_i, bus.lat_wdata_i});
        m_ready = q.size() < DEPTH;
        m_pend = m_wen ? 32'd1 << m_addr : 32'd0;
        foreach (q[i]) m_pend[q[i].a] = 1'b1;
    endtask

    task automatic compare();
        chk("reg_wen", bus.reg_wen_o, m_wen);
        if (m_wen) begin
            chk("reg_waddr", bus.reg_waddr_o, m_addr);
            chk("reg_wdata", bus.reg_wdata_o, m_data);
        end
        chk("pend_mask", bus.pend_mask_o, m_pend);
        chk("lat_ready", bus.lat_ready_o, m_ready);
        chk("alu_stall", bus.alu_stall_o, m_starve == LIMIT);
`ifdef WB_ARB_STATS_EN
        chk("stat_conflict", stat, m_stat[31:0]);
`endif
    endtask

    task automatic cycle();
        model();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic drive(bit aw, logic [4:0] aa, logic [63:0] ad, bit lv, logic [4:0] la, logic [63:0] ld);
        bus.alu_wen_i   = aw;
        bus.alu_waddr_i = aa;
        bus.alu_wdata_i = ad;
        bus.lat_valid_i = lv;
        bus.lat_waddr_i = la;
        bus.lat_wdata_i = ld;
    endtask

    task automatic drive_rand();
        drive($urandom_range(0, 1), 5'($urandom_range(0, 15)), {$urandom, $urandom},
              $urandom_range(0, 9) < 6, 5'($urandom_range(0, 15)), {$urandom, $urandom});
    endtask

    initial begin
        int   pushes, stalls;
        logic [4:0] drained[$];
        bit   acc;
        drive(0, 0, 0, 0, 0, 0);
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            cycle();
        end
        chk("rst_wen", bus.reg_wen_o, 0);
        chk("rst_ready", bus.lat_ready_o, 0);
        chk("rst_pend", bus.pend_mask_o, 0);
        chk("rst_stall", bus.alu_stall_o, 0);
        rst = 0;
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        chk("ready_after_rst", bus.lat_ready_o, 1);

        drive(1, 5, 64'hDEAD, 0, 0, 0);
        cycle();
        chk("alu_wen", bus.reg_wen_o, 1);
        chk("alu_addr", bus.reg_waddr_o, 5);
        chk("alu_data", bus.reg_wdata_o, 64'hDEAD);
        drive(1, 0, 64'hBEEF, 0, 0, 0);
        cycle();
        chk("alu_x0", bus.reg_wen_o, 0);

        drive(1, 3, 64'h11, 1, 7, 64'h22);
        cycle();
        chk("col_addr1", bus.reg_waddr_o, 3);
        chk("col_pend7a", bus.pend_mask_o[7], 1);
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        chk("col_wen2", bus.reg_wen_o, 1);
        chk("col_addr2", bus.reg_waddr_o, 7);
        chk("col_data2", bus.reg_wdata_o, 64'h22);
        chk("col_pend7b", bus.pend_mask_o[7], 1);
        cycle();
        chk("col_pend7c", bus.pend_mask_o[7], 0);

        drive(0, 0, 0, 1, 9, 64'h5A);
        cycle();
        chk("byp_wen", bus.reg_wen_o, 1);
        chk("byp_addr", bus.reg_waddr_o, 9);
        chk("byp_data", bus.reg_wdata_o, 64'h5A);
        chk("byp_pend", bus.pend_mask_o, 32'h200);
        chk("lat_x0_rdy", bus.lat_ready_o, 1);
        drive(0, 0, 0, 1, 0, 64'h77);
        cycle();
        chk("lat_x0", bus.reg_wen_o, 0);
        drive(0, 0, 0, 0, 0, 0);
        cycle();

        pushes = 0;
        stalls = 0;
        for (int c = 0; c < 22; c++) begin
            drive(1, 1, 64'(c), pushes < 3, 5'(10 + pushes), 64'(100 + pushes));
            acc = bus.lat_valid_i && m_ready;
            cycle();
            if (acc) begin
                pushes++;
                if (pushes == 2) chk("full_ready", bus.lat_ready_o, 0);
            end
            if (bus.alu_stall_o) stalls++;
            if (bus.reg_wen_o && bus.reg_waddr_o >= 10) drained.push_back(bus.reg_waddr_o);
        end
        chk("stall_pulses", stalls, 3);
        chk("drain_count", drained.size(), 3);
        for (int i = 0; i < drained.size(); i++) chk("drain_order", drained[i], 64'(10 + i));

        for (int c = 0; c < 600; c++) begin
            rst = $urandom_range(0, 99) == 0;
            drive_rand();
            cycle();
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
